// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester bridge: FSM state encoding and default widths.
package apb_pkg;

  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_TMO_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_master_state_e;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS wait cycles; expired flags that one more stalled cycle exhausts the budget.
module apb_timeout_counter #(
  parameter int WIDTH = 8
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  // The stall seen in this cycle is the one that brings the count to the limit.
  assign expired = (count == limit - WIDTH'(1));

endmodule

// File: rtl/apb_master_bridge.sv
// Local command/response port to single-outstanding APB requester with wait-state timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output apb_master_state_e     dbg_state
);

  // Handshakes: a command transfers on a rising edge with cmd_valid && cmd_ready,
  // a response on a rising edge with rsp_valid && rsp_ready; rsp_* hold while rsp_valid && !rsp_ready.

  localparam logic [APB_TMO_WIDTH-1:0] TIMEOUT_LIMIT = APB_TMO_WIDTH'(TIMEOUT_CYCLES);

  apb_master_state_e state, next_state;

  logic                  wait_expired;
  logic                  accept;
  logic                  access_done;
  logic                  access_tmo;

  logic                  psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic                  rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;

  assign cmd_ready   = (state == ST_IDLE) && PRESETn;
  assign dbg_state   = state;
  assign accept      = cmd_valid && (state == ST_IDLE);
  assign access_done = (state == ST_ACCESS) && PREADY;
  assign access_tmo  = (state == ST_ACCESS) && !PREADY && wait_expired;

  apb_timeout_counter #(
    .WIDTH (APB_TMO_WIDTH)
  ) u_wait_cnt (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clear   (state == ST_SETUP),
    .enable  ((state == ST_ACCESS) && !PREADY),
    .limit   (TIMEOUT_LIMIT),
    .expired (wait_expired)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin : state_reg
    if (!PRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin : next_state_logic
    next_state = state;
    case (state)
      ST_IDLE:   if (cmd_valid) next_state = ST_SETUP;
      ST_SETUP:  next_state = ST_ACCESS;
      ST_ACCESS: if (PREADY || wait_expired) next_state = ST_RESP;
      ST_RESP:   if (rsp_ready) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Output values are computed for the state being entered, then registered.
  always_comb begin : output_logic
    psel_d        = (next_state == ST_SETUP) || (next_state == ST_ACCESS);
    penable_d     = (next_state == ST_ACCESS);
    pwrite_d      = PWRITE;
    paddr_d       = PADDR;
    pwdata_d      = PWDATA;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    if (accept) begin
      pwrite_d = cmd_write;
      paddr_d  = cmd_addr;
      pwdata_d = cmd_wdata;
    end
    if (access_done) begin
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = PWRITE ? '0 : PRDATA;
      rsp_err_d     = PSLVERR;
      rsp_timeout_d = 1'b0;
    end else if (access_tmo) begin
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_err_d     = 1'b1;
      rsp_timeout_d = 1'b1;
    end
    if ((state == ST_RESP) && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin : output_reg
    if (!PRESETn) begin
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PADDR       <= paddr_d;
      PWDATA      <= pwdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed scenarios then random transfers against a memory-level model.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int TIMEOUT = 16;

  typedef struct {
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
  } apb_rec_t;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA  = '0;
  logic        PREADY  = 1'b0;
  logic        PSLVERR = 1'b0;
  apb_master_state_e dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  int cfg_waits = 0;
  logic cfg_err = 1'b0;
  int acc_cnt = 0;

  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] exp_q [$];
  apb_rec_t    apb_q [$];

  apb_master_bridge #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction

  // completer: ready after cfg_waits stalled ACCESS cycles, junk on PREADY/PRDATA/PSLVERR elsewhere
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      if (acc_cnt == cfg_waits) begin
        PREADY  = 1'b1;
        PSLVERR = cfg_err;
        PRDATA  = PWRITE ? $urandom : (slave_mem.exists(PADDR) ? slave_mem[PADDR] : dflt(PADDR));
        apb_q.push_back('{pwrite: PWRITE, paddr: PADDR, pwdata: PWDATA});
        if (PWRITE && !cfg_err) slave_mem[PADDR] = PWDATA;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom);
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      PREADY  = 1'($urandom);
      PRDATA  = $urandom;
      PSLVERR = 1'($urandom);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver + scoreboard for one complete transfer
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input int waits, input logic err, input int hold, input bit keep_valid);
    logic        exp_to, exp_err;
    int          exp_acc, acc, n;
    bit          addr_ok, hold_ok;
    logic [31:0] r_rdata;
    logic        r_err, r_to;
    apb_rec_t    rec;

    exp_to  = (waits >= TIMEOUT);
    exp_acc = exp_to ? TIMEOUT : waits + 1;
    exp_err = exp_to | err;
    exp_q.push_back((wr || exp_to) ? 32'h0 : model_rd(addr));
    if (wr && !exp_to && !err) model_mem[addr] = data;

    cfg_waits = waits;
    cfg_err   = err;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge PCLK); #1;
      n++;
    end
    check("cmd_ready_before_accept", 32'(cmd_ready), 32'h1);
    @(posedge PCLK); #1;
    if (!keep_valid) cmd_valid = 1'b0;
    check("setup_phase", 32'({PSEL, PENABLE, cmd_ready}), 32'b100);

    acc = 0;
    addr_ok = 1'b1;
    n = 0;
    do begin
      @(posedge PCLK); #1;
      if (PSEL && PENABLE) begin
        acc++;
        if (PADDR !== addr || PWRITE !== wr || PWDATA !== data) addr_ok = 1'b0;
      end
      n++;
    end while (PSEL && PENABLE && n < 300);
    check("access_cycles", 32'(acc), 32'(exp_acc));
    check("paddr_stable", 32'(addr_ok), 32'h1);
    check("resp_phase", 32'({rsp_valid, PSEL, PENABLE}), 32'b100);
    check("rsp_rdata", rsp_rdata, exp_q.pop_front());
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));

    if (exp_to) begin
      check("apb_none_on_timeout", 32'(apb_q.size()), 32'h0);
    end else begin
      check("apb_one_completion", 32'(apb_q.size()), 32'h1);
      if (apb_q.size() > 0) begin
        rec = apb_q.pop_front();
        check("apb_paddr", rec.paddr, addr);
        if (wr) check("apb_pwdata", rec.pwdata, data);
      end
    end
    apb_q.delete();

    r_rdata = rsp_rdata;
    r_err   = rsp_err;
    r_to    = rsp_timeout;
    hold_ok = 1'b1;
    rsp_ready = 1'b0;
    repeat (hold) begin
      @(posedge PCLK); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== r_rdata || rsp_err !== r_err ||
          rsp_timeout !== r_to || cmd_ready !== 1'b0 || PSEL !== 1'b0) hold_ok = 1'b0;
    end
    check("rsp_hold_stable", 32'(hold_ok), 32'h1);
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    check("rsp_done_idle", 32'({rsp_valid, cmd_ready, PSEL}), 32'b010);
  endtask

  initial begin
    logic        wr, err;
    logic [31:0] addr;
    int          waits, sel;
    bit          quiet;

    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;

    // reset values
    repeat (2) @(negedge PCLK);
    check("rst_psel_penable", 32'({PSEL, PENABLE, PWRITE}), 32'h0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_rsp_flags", 32'({rsp_valid, rsp_err, rsp_timeout}), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);

    // zero-wait write, then 3-wait read back
    xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 0, 1'b0);
    xfer(1'b0, 32'h0000_0010, 32'h0, 3, 1'b0, 0, 1'b0);
    // slave error on read still returns sampled data
    xfer(1'b0, 32'h0000_0020, 32'h0, 0, 1'b1, 1, 1'b0);
    // timeout, and PREADY on the last allowed cycle
    xfer(1'b0, 32'h0000_0010, 32'h0, 1000, 1'b0, 0, 1'b0);
    xfer(1'b0, 32'h0000_0010, 32'h0, TIMEOUT - 1, 1'b0, 0, 1'b0);
    xfer(1'b1, 32'h0000_0024, 32'h1234_5678, TIMEOUT, 1'b0, 0, 1'b0);
    // response back-pressure with cmd_valid held, next command right behind
    xfer(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 0, 1'b0, 5, 1'b1);
    xfer(1'b0, 32'h0000_0030, 32'h0, 0, 1'b0, 0, 1'b0);

    // reset during ACCESS
    cfg_waits = 1000;
    cfg_err   = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0040;
    cmd_wdata = 32'h5555_AAAA;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    check("pre_reset_access", 32'({PSEL, PENABLE}), 32'b11);
    #2 PRESETn = 1'b0;
    #1;
    check("async_reset_drop", 32'({PSEL, PENABLE, rsp_valid, cmd_ready}), 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    quiet = 1'b1;
    repeat (3) begin
      @(posedge PCLK); #1;
      if (rsp_valid !== 1'b0 || PSEL !== 1'b0) quiet = 1'b0;
    end
    check("no_rsp_after_reset", 32'(quiet), 32'h1);
    check("ready_after_reset", 32'(cmd_ready), 32'h1);
    check("no_apb_after_reset", 32'(apb_q.size()), 32'h0);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = 32'($urandom_range(0, 15)) << 2;
      sel   = $urandom_range(0, 9);
      waits = (sel < 7) ? $urandom_range(0, 3) : $urandom_range(TIMEOUT - 3, TIMEOUT + 2);
      err   = ($urandom_range(0, 7) == 0);
      xfer(wr, addr, $urandom, waits, err, $urandom_range(0, 2), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
